axis_lutram_fifo_ctl: RTL and testbench
=======================================

Name: axis_lutram_fifo_ctl

Overview:
Sequencing controller that turns an external sdp_lut_ram instance into an AXI-Stream FIFO. Owns the write/read pointers and full/empty/count state. Drives the RAM's write port and read address, and presents the RAM's asynchronous read data as the master stream. Used in axis_cpu wherever a small stream buffer is needed, for example instruction or result queues between datapath stages.

Parameters:
DATA_WIDTH, 32, stream word width; must match the attached RAM.
ADDR_WIDTH, 4, RAM address width; FIFO depth DEPTH = 2**ADDR_WIDTH (legal range 1..8).

Ports:
clk  in  1  sole clock; all state updates on posedge.
rst_n  in  1  asynchronous, active-low reset.
s_axis_tdata  in  DATA_WIDTH  input word.
s_axis_tvalid  in  1  input valid.
s_axis_tready  out  1  input ready.
m_axis_tdata  out  DATA_WIDTH  output word.
m_axis_tvalid  out  1  output valid.
m_axis_tready  in  1  output ready.
ram_wr_en  out  1  RAM write enable.
ram_wr_addr  out  ADDR_WIDTH  RAM write address.
ram_din  out  DATA_WIDTH  RAM write data.
ram_rd_addr  out  ADDR_WIDTH  RAM read address; RAM read is combinational.
ram_rd_data  in  DATA_WIDTH  RAM read data.
count  out  ADDR_WIDTH+1  current occupancy.

Behaviour:
- State registers:
  - wr_ptr and rd_ptr, each ADDR_WIDTH+1 bits, where the MSB is the wrap bit.
  - run flop.
  - All reset asynchronously to 0.
- run rises to 1 on the first posedge after rst_n deasserts and then stays 1. s_axis_tready is held 0 while run=0.
- Status decoding:
  - empty = (wr_ptr == rd_ptr).
  - full = (low bits equal) and (MSBs differ).
  - count = wr_ptr - rd_ptr, modulo 2**(ADDR_WIDTH+1); range 0..DEPTH.
- s_axis_tready = run & !full. It depends only on state, never on m_axis_tready, so there is no ready pass-through.
- push = s_axis_tvalid & s_axis_tready.
  - ram_wr_en = push; ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0]; ram_din = s_axis_tdata. All are combinational.
  - wr_ptr increments on each posedge where push=1.
- m_axis_tvalid = !empty.
  - ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0]; m_axis_tdata = ram_rd_data (combinational).
  - pop = m_axis_tvalid & m_axis_tready; rd_ptr increments on each posedge where pop=1.
- Latency: a word pushed at edge N appears on m_axis in the cycle after edge N, with m_axis_tvalid=1. Throughput is one word per cycle each direction.
- Simultaneous push and pop: both pointers advance and count is unchanged. This is legal at any count 1..DEPTH-1.
- Boundaries:
  - When full, push is blocked even if pop=1 in the same cycle; tready recovers the next cycle.
  - When empty, m_axis_tvalid=0, so a word being pushed is never forwarded in the same cycle.
- Pointer wrap: the low bits wrap modulo DEPTH and the MSB toggles. The full/empty encoding relies on this.
- AXIS rule: m_axis_tdata is stable while m_axis_tvalid=1 and m_axis_tready=0. The RAM location at rd_ptr cannot be overwritten until it is popped, because full blocks the push.
- Reset mid-operation: all contents are discarded immediately (asynchronous).
  - Outputs go to count=0, m_axis_tvalid=0, s_axis_tready=0, ram_wr_en=0.
  - RAM contents are not cleared and are unreachable.

Optional Feature:
Macro: AXIS_LUTRAM_FIFO_OREG_EN.
- Defined: adds an output register stage (oreg_data, oreg_valid; oreg_valid resets to 0).
  - m_axis_tvalid = oreg_valid; m_axis_tdata = oreg_data.
  - The register loads ram_rd_data and advances rd_ptr when the RAM is not empty and (!oreg_valid | m_axis_tready).
  - Push-to-output latency becomes 2 cycles. Capacity becomes DEPTH+1, and count includes oreg_valid.
  - Full throughput is kept with m_axis_tready held at 1.
- Undefined: purely combinational output path as described above.

Test Plan:
1. Reset, then push 0..15 with m_axis_tready=0 -> s_axis_tready=0 after the 16th push, count=16 (17 with OREG after load); drain gives 0..15 in order, count=0, m_axis_tvalid=0.
2. Hold count=5, assert tvalid/tready on both sides for 10 cycles -> count stays 5 each cycle; output order is continuous.
3. Continuous streaming of 40 words with both readies at 1 -> every word appears exactly once, in order, across two pointer wraps; one word per cycle after the initial latency.
4. Full FIFO with a pop and a push in the same cycle -> the push is refused (ram_wr_en=0); next cycle s_axis_tready=1, count=15.
5. Random backpressure on m_axis_tready for 500 words -> no loss or duplication; m_axis_tdata stable whenever tvalid=1 and tready=0.
6. Assert rst_n=0 with count=7 -> count=0, m_axis_tvalid=0, s_axis_tready=0 immediately; s_axis_tready=1 one edge after release.

Source files
------------

// File: rtl/axis_lutram_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : axis_lutram_fifo_ctl
// Description : Sequencing controller that wraps an external simple-dual-port
//               LUT RAM (synchronous write, combinational read) into an
//               AXI-Stream FIFO. Owns the write/read pointers and the
//               full/empty/occupancy state, drives the RAM write port and read
//               address, and presents the RAM read data as the master stream.
//
// Ports       : clk, rst_n                 clock, asynchronous active-low reset
//               s_axis_tdata/tvalid/tready slave stream (write side)
//               m_axis_tdata/tvalid/tready master stream (read side)
//               ram_wr_en/wr_addr/din      RAM write port
//               ram_rd_addr/rd_data        RAM combinational read port
//               count                      current occupancy
//
// Options     : AXIS_LUTRAM_FIFO_OREG_EN   when defined, inserts an output
//               register stage between the RAM read port and m_axis. Capacity
//               becomes DEPTH+1 and push-to-output latency becomes 2 cycles.
//
// Revision    : 1.0 - initial release
// ============================================================================
module axis_lutram_fifo_ctl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int c_ptr_w = ADDR_WIDTH + 1;

  // Pointers carry one extra wrap bit so that full and empty are
  // distinguishable when the low (address) bits coincide.
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic               run_q, run_d;

  logic               w_ram_empty;
  logic               w_ram_full;
  logic               w_push;
  logic               w_rd_adv;
  logic [c_ptr_w-1:0] w_ram_count;

  assign w_ram_empty = (wr_ptr_q == rd_ptr_q);
  assign w_ram_full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                       (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);
  assign w_ram_count = wr_ptr_q - rd_ptr_q;

  // Ready is a function of state only; a pop in the same cycle does not
  // release a full FIFO, which keeps the slave side free of any
  // combinational path from m_axis_tready.
  assign s_axis_tready = run_q & ~w_ram_full;
  assign w_push        = s_axis_tvalid & s_axis_tready;

  assign ram_wr_en   = w_push;
  assign ram_wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
  assign ram_din     = s_axis_tdata;
  assign ram_rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

`ifdef AXIS_LUTRAM_FIFO_OREG_EN
  logic [DATA_WIDTH-1:0] oreg_data_q, oreg_data_d;
  logic                  oreg_valid_q, oreg_valid_d;

  // The output register takes the RAM head whenever it is empty or is being
  // drained this cycle, so a continuously-ready sink sees one word per cycle.
  assign w_rd_adv = ~w_ram_empty & (~oreg_valid_q | m_axis_tready);

  always_comb begin
    oreg_data_d  = oreg_data_q;
    oreg_valid_d = oreg_valid_q;
    if (w_rd_adv) begin
      oreg_data_d  = ram_rd_data;
      oreg_valid_d = 1'b1;
    end else if (m_axis_tready) begin
      oreg_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oreg_data_q  <= '0;
      oreg_valid_q <= 1'b0;
    end else begin
      oreg_data_q  <= oreg_data_d;
      oreg_valid_q <= oreg_valid_d;
    end
  end

  assign m_axis_tvalid = oreg_valid_q;
  assign m_axis_tdata  = oreg_data_q;
  // Occupancy includes the word parked in the output register.
  assign count         = w_ram_count + {{ADDR_WIDTH{1'b0}}, oreg_valid_q};
`else
  // Head word is read straight from the RAM; it cannot change under a stalled
  // sink because the full check prevents overwriting the location at rd_ptr.
  assign m_axis_tvalid = ~w_ram_empty;
  assign m_axis_tdata  = ram_rd_data;
  assign w_rd_adv      = m_axis_tvalid & m_axis_tready;
  assign count         = w_ram_count;
`endif

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    // Run rises on the first edge after reset release and stays high; it
    // holds off the slave side for that first cycle.
    run_d    = 1'b1;
    if (w_push) begin
      wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
    end
    if (w_rd_adv) begin
      rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      run_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      run_q    <= run_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axis_lutram_fifo_ctl.sv
`default_nettype none
// ============================================================================
// Module      : tb_axis_lutram_fifo_ctl
// Description : Self-checking bench for axis_lutram_fifo_ctl. Models the
//               attached LUT RAM, keeps a scoreboard of accepted words and
//               checks ordering, occupancy, ready/valid boundaries, AXIS
//               data stability under backpressure and asynchronous reset.
//               Honours AXIS_LUTRAM_FIFO_OREG_EN for capacity and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_lutram_fifo_ctl;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 4;
  localparam int DEPTH      = 2 ** ADDR_WIDTH;
`ifdef AXIS_LUTRAM_FIFO_OREG_EN
  localparam int CAP = DEPTH + 1;
  localparam int LAT = 2;
`else
  localparam int CAP = DEPTH;
  localparam int LAT = 1;
`endif

  logic                  clk;
  logic                  rst_n;
  logic [DATA_WIDTH-1:0] s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic                  ram_wr_en;
  logic [ADDR_WIDTH-1:0] ram_wr_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic [ADDR_WIDTH:0]   count;

  axis_lutram_fifo_ctl #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_din      (ram_din),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .count        (count)
  );

  // Attached RAM: synchronous write, combinational read.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_din;
  end
  assign ram_rd_data = mem[ram_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int n_push   = 0;
  int n_pop    = 0;
  logic [DATA_WIDTH-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    m_axis_tready = 1'b1;
    s_axis_tvalid = 1'b0;
    for (int g = 0; g < 200 && m_axis_tvalid; g++) step();
    check_eq({tag, "_vld0"}, m_axis_tvalid, 0);
    check_eq({tag, "_cnt0"}, count, 0);
    check_eq({tag, "_qempty"}, exp_q.size(), 0);
  endtask

  // Handshake monitor, sampled mid-cycle: scoreboard ordering plus AXIS
  // stability of a stalled master word.
  logic                  hold;
  logic [DATA_WIDTH-1:0] hold_data;
  initial hold = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        check_eq("stall_vld", m_axis_tvalid, 1);
        check_eq("stall_data", m_axis_tdata, hold_data);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check_eq("pop_avail", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check_eq("pop_data", m_axis_tdata, exp_q.pop_front());
        n_pop++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        exp_q.push_back(s_axis_tdata);
        n_push++;
      end
      hold      = m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
    end
  end

  int base;

  initial begin
    rst_n         = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD_BEEF;
    m_axis_tready = 1'b0;
    step();
    step();
    // Reset state
    check_eq("rst_cnt", count, 0);
    check_eq("rst_mvld", m_axis_tvalid, 0);
    check_eq("rst_srdy", s_axis_tready, 0);
    check_eq("rst_wren", ram_wr_en, 0);
    rst_n = 1'b1;
    #1;
    check_eq("run_srdy0", s_axis_tready, 0);
    step();
    s_axis_tvalid = 1'b0;
    check_eq("run_srdy1", s_axis_tready, 1);

    // Fill to capacity with the sink stalled
    for (int i = 0; i < CAP; i++) begin
      check_eq("t1_srdy", s_axis_tready, 1);
      s_axis_tdata  = DATA_WIDTH'(i);
      s_axis_tvalid = 1'b1;
      #1;
      check_eq("t1_wren", ram_wr_en, 1);
      check_eq("t1_waddr", ram_wr_addr, i % DEPTH);
      step();
    end
    s_axis_tvalid = 1'b0;
    check_eq("t1_full_srdy", s_axis_tready, 0);
    check_eq("t1_full_cnt", count, CAP);
    check_eq("t1_head_vld", m_axis_tvalid, 1);
    check_eq("t1_head_data", m_axis_tdata, 0);

    // Full: pop and push in the same cycle, push must be refused
    s_axis_tdata  = 32'h0000_00AA;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    #1;
    check_eq("t4_wren", ram_wr_en, 0);
    check_eq("t4_srdy", s_axis_tready, 0);
    step();
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    check_eq("t4_cnt", count, CAP - 1);
    check_eq("t4_srdy_rec", s_axis_tready, 1);
    drain("t1");

    // Hold occupancy at 5 with simultaneous push/pop
    m_axis_tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_axis_tdata  = DATA_WIDTH'(200 + i);
      s_axis_tvalid = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    step();
    check_eq("t2_cnt_init", count, 5);
    for (int k = 0; k < 10; k++) begin
      s_axis_tdata  = DATA_WIDTH'(300 + k);
      s_axis_tvalid = 1'b1;
      m_axis_tready = 1'b1;
      step();
      check_eq("t2_cnt_hold", count, 5);
    end
    drain("t2");

    // Continuous streaming across two pointer wraps
    base = n_pop;
    m_axis_tready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      check_eq("t3_srdy", s_axis_tready, 1);
      check_eq("t3_stream_vld", m_axis_tvalid, i >= LAT);
      s_axis_tdata  = DATA_WIDTH'(400 + i);
      s_axis_tvalid = 1'b1;
      step();
    end
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    check_eq("t3_done_vld", m_axis_tvalid, 0);
    check_eq("t3_npop", n_pop - base, 40);
    check_eq("t3_qempty", exp_q.size(), 0);

    // Random backpressure, 500 words
    base = n_push;
    for (int g = 0; g < 5000 && (n_push - base) < 500; g++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = $urandom;
      m_axis_tready = 1'($urandom_range(0, 1));
      step();
    end
    s_axis_tvalid = 1'b0;
    check_eq("t5_pushed", n_push - base, 500);
    drain("t5");

    // Asynchronous reset with 7 words held
    m_axis_tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      s_axis_tdata  = DATA_WIDTH'(500 + i);
      s_axis_tvalid = 1'b1;
      step();
    end
    check_eq("t6_cnt7", count, 7);
    rst_n = 1'b0;
    #1;
    check_eq("t6_cnt0", count, 0);
    check_eq("t6_mvld", m_axis_tvalid, 0);
    check_eq("t6_srdy", s_axis_tready, 0);
    check_eq("t6_wren", ram_wr_en, 0);
    exp_q.delete();
    s_axis_tvalid = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    check_eq("t6_srdy_rel", s_axis_tready, 0);
    step();
    check_eq("t6_srdy_run", s_axis_tready, 1);
    check_eq("t6_cnt_run", count, 0);
    s_axis_tdata  = 32'h0000_0077;
    s_axis_tvalid = 1'b1;
    m_axis_tready = 1'b1;
    step();
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < LAT; i++) step();
    check_eq("t6_post_qempty", exp_q.size(), 0);
    check_eq("t6_post_cnt", count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
